// File: rtl/mse_error_accumulator.sv
// Measures the error of a 16-bit approximate adder over a window of 2^LOG2N samples:
// sum of squared errors (scaled to a mean), largest |error| and count of wrong results.
module mse_error_accumulator #(
  parameter int LOG2N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] IN1,
  input  logic [15:0] IN2,
  input  logic [16:0] APPROX,
  output logic [33:0] mse,
  output logic [16:0] max_abs_err,
  output logic [16:0] err_count,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam int N = 1 << LOG2N;
  localparam int SUM_W = 34 + LOG2N;
  localparam logic [16:0] LAST = 17'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Handshake: a sample is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in RUN and never depends on in_valid.

  state_t           state;
  logic [16:0]      cnt;
  logic             s1_v;
  logic [17:0]      s1_err;
  logic [SUM_W-1:0] sum;
  logic [16:0]      acc_max;
  logic [16:0]      acc_cnt;

  logic        accept;
  logic [16:0] exact;
  logic [17:0] neg_err;
  logic [16:0] abs_err;
  logic [33:0] sq_err;

  assign accept    = in_valid && in_ready;
  assign exact     = {1'b0, IN1} + {1'b0, IN2};
  assign neg_err   = -s1_err;
  // |err| never exceeds 2^17-1, so 17 bits hold it and 34 bits hold its square.
  assign abs_err   = s1_err[17] ? neg_err[16:0] : s1_err[16:0];
  assign sq_err    = {17'd0, abs_err} * {17'd0, abs_err};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      done        <= 1'b0;
      cnt         <= '0;
      s1_v        <= 1'b0;
      s1_err      <= '0;
      sum         <= '0;
      acc_max     <= '0;
      acc_cnt     <= '0;
      mse         <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_err <= {1'b0, APPROX} - {1'b0, exact};
      end

      if (s1_v) begin
        sum <= sum + SUM_W'(sq_err);
        if (abs_err >= acc_max) begin
          acc_max <= abs_err;
        end
        if (s1_err != 18'd0) begin
          acc_cnt <= acc_cnt + 17'd1;
        end
      end

      case (state)
        IDLE, DONE: begin
          // The pipeline is empty here, so clearing cannot race an accumulation.
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            done     <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            acc_max  <= '0;
            acc_cnt  <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + 17'd1;
            if (cnt == LAST) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Stage 1 empty means the last sample has already been folded in.
          if (!s1_v) begin
            state       <= DONE;
            done        <= 1'b1;
            mse         <= sum[SUM_W-1:LOG2N];
            max_abs_err <= acc_max;
            err_count   <= acc_cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mse_error_accumulator.sv
// Bench for mse_error_accumulator: 4-sample windows (LOG2N=2) from a table and random data,
// a single-sample window (LOG2N=0) and the full-scale worst case (LOG2N=16).
module tb_mse_error_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_bc;

  logic        a_start, a_valid, a_ready, a_done;
  logic [15:0] a_in1, a_in2;
  logic [16:0] a_approx, a_max, a_cnt;
  logic [33:0] a_mse;
  logic [1:0]  a_state;

  logic        b_start, b_valid, b_ready, b_done;
  logic [15:0] b_in1, b_in2;
  logic [16:0] b_approx, b_max, b_cnt;
  logic [33:0] b_mse;
  logic [1:0]  b_state;

  logic        c_start, c_valid, c_ready, c_done;
  logic [15:0] c_in1, c_in2;
  logic [16:0] c_approx, c_max, c_cnt;
  logic [33:0] c_mse;
  logic [1:0]  c_state;

  mse_error_accumulator #(.LOG2N(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
    .IN1(a_in1), .IN2(a_in2), .APPROX(a_approx), .mse(a_mse), .max_abs_err(a_max),
    .err_count(a_cnt), .done(a_done), .state_dbg(a_state)
  );

  mse_error_accumulator #(.LOG2N(0)) dut_b (
    .clk(clk), .rst_n(rst_bc), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
    .IN1(b_in1), .IN2(b_in2), .APPROX(b_approx), .mse(b_mse), .max_abs_err(b_max),
    .err_count(b_cnt), .done(b_done), .state_dbg(b_state)
  );

  mse_error_accumulator #(.LOG2N(16)) dut_c (
    .clk(clk), .rst_n(rst_bc), .start(c_start), .in_valid(c_valid), .in_ready(c_ready),
    .IN1(c_in1), .IN2(c_in2), .APPROX(c_approx), .mse(c_mse), .max_abs_err(c_max),
    .err_count(c_cnt), .done(c_done), .state_dbg(c_state)
  );

  typedef struct packed {
    logic [3:0][15:0] i1;
    logic [3:0][15:0] i2;
    logic [3:0][16:0] ap;
    logic [33:0]      mse;
    logic [16:0]      mx;
    logic [16:0]      cnt;
  } vec_t;

  vec_t tbl[4];

  int checks = 0;
  int failures = 0;
  logic [67:0] exp_q[$];

  logic [15:0] w1[4];
  logic [15:0] w2[4];
  logic [16:0] wa[4];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Scoreboard: every rising edge of done retires one expected window result.
  logic a_done_q = 1'b0;
  always @(negedge clk) begin
    if (a_done && !a_done_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h required=none", {a_mse, a_max, a_cnt});
      end else begin
        check("window_result", {a_mse, a_max, a_cnt}, exp_q.pop_front());
      end
    end
    a_done_q <= a_done;
  end

  function automatic logic [67:0] model();
    longint s;
    logic [16:0] mx;
    logic [16:0] cn;
    s = 0;
    mx = '0;
    cn = '0;
    for (int i = 0; i < 4; i++) begin
      int e;
      int ae;
      e = int'(wa[i]) - int'(w1[i]) - int'(w2[i]);
      ae = (e < 0) ? -e : e;
      s += longint'(ae) * longint'(ae);
      if (ae > int'(mx)) mx = 17'(ae);
      if (e != 0) cn = cn + 17'd1;
    end
    return {34'(s >> 2), mx, cn};
  endfunction

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      w1[i] = v.i1[i];
      w2[i] = v.i2[i];
      wa[i] = v.ap[i];
    end
  endtask

  // Called #1 after a rising edge with dut_a in IDLE or DONE.
  task automatic a_run(input int stall_after, input bit poke, input logic [67:0] exp);
    int k;
    int stalls;
    int guard;
    bit acc;
    k = 0;
    stalls = 0;
    guard = 0;
    exp_q.push_back(exp);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    while (k < 4 && guard < 50) begin
      guard++;
      if (k == stall_after && stalls < 5) begin
        a_valid = 1'b0;
        a_start = poke && (stalls == 2);
        a_in1 = 16'($urandom_range(0, 65535));
        a_approx = 17'($urandom_range(0, 131071));
        stalls++;
      end else begin
        a_valid = 1'b1;
        a_start = 1'b0;
        a_in1 = w1[k];
        a_in2 = w2[k];
        a_approx = wa[k];
      end
      acc = a_valid && a_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    a_valid = 1'b0;
    a_start = 1'b0;
    if (k < 4) begin
      fail_now("window_accept");
    end else begin
      check("drain_ready", 68'(a_ready), 68'(0));
      @(posedge clk); #1;
      check("done_not_early", 68'(a_done), 68'(0));
      @(posedge clk); #1;
      check("done_latency", 68'(a_done), 68'(1));
      // Samples offered in DONE must be ignored and results must hold.
      a_valid = 1'b1;
      a_in1 = 16'hFFFF;
      a_in2 = 16'hFFFF;
      a_approx = 17'd0;
      repeat (3) @(posedge clk);
      #1;
      a_valid = 1'b0;
      check("hold_in_done", {a_mse, a_max, a_cnt}, exp);
    end
  endtask

  task automatic b_one(input logic [15:0] i1, input logic [15:0] i2, input logic [16:0] ap,
                       input logic [67:0] exp);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_valid = 1'b1;
    b_in1 = i1;
    b_in2 = i2;
    b_approx = ap;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("b_drain_ready", 68'(b_ready), 68'(0));
    @(posedge clk); #1;
    check("b_done_not_early", 68'(b_done), 68'(0));
    @(posedge clk); #1;
    check("b_done_latency", 68'(b_done), 68'(1));
    check("b_result", {b_mse, b_max, b_cnt}, exp);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_bc = 1'b0;
    a_start = 0; a_valid = 0; a_in1 = '0; a_in2 = '0; a_approx = '0;
    b_start = 0; b_valid = 0; b_in1 = '0; b_in2 = '0; b_approx = '0;
    c_start = 0; c_valid = 0; c_in1 = '0; c_in2 = '0; c_approx = '0;

    tbl[0].i1 = {16'h0005, 16'hFFFF, 16'h0000, 16'h1234};
    tbl[0].i2 = {16'h0007, 16'hFFFF, 16'h0000, 16'h0F0F};
    tbl[0].ap = {17'h0000C, 17'h1FFFE, 17'h00000, 17'h02143};
    tbl[0].mse = 34'd0; tbl[0].mx = 17'd0; tbl[0].cnt = 17'd0;
    tbl[1].i1 = {4{16'h0010}};
    tbl[1].i2 = {4{16'h0003}};
    tbl[1].ap = {4{17'h00010}};
    tbl[1].mse = 34'd9; tbl[1].mx = 17'd3; tbl[1].cnt = 17'd4;
    tbl[2].i1 = {4{16'd100}};
    tbl[2].i2 = {4{16'd200}};
    tbl[2].ap = {17'd302, 17'd295, 17'd300, 17'd301};
    tbl[2].mse = 34'd7; tbl[2].mx = 17'd5; tbl[2].cnt = 17'd3;
    tbl[3].i1 = {4{16'h0000}};
    tbl[3].i2 = {4{16'h0000}};
    tbl[3].ap = {4{17'h1FFFF}};
    tbl[3].mse = 34'h3FFFC0001; tbl[3].mx = 17'h1FFFF; tbl[3].cnt = 17'd4;

    #3;
    check("reset_results", {a_mse, a_max, a_cnt}, 68'd0);
    check("reset_flags", {64'd0, a_done, a_ready, a_state}, 68'd0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    rst_bc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_auto_start", {64'd0, a_done, a_ready, a_state}, 68'd0);

    fork
      begin : big_run
        int guard;
        guard = 0;
        c_in1 = 16'hFFFF;
        c_in2 = 16'hFFFF;
        c_approx = 17'd0;
        c_start = 1'b1;
        @(posedge clk); #1;
        c_start = 1'b0;
        c_valid = 1'b1;
        while (!c_done && guard < 70000) begin
          @(posedge clk); #1;
          guard++;
        end
        c_valid = 1'b0;
        if (!c_done) fail_now("c_done");
        else check("c_worst_case", {c_mse, c_max, c_cnt}, {34'h3FFF80004, 17'h1FFFE, 17'h10000});
      end
      begin : main_run
        b_one(16'h0010, 16'h0003, 17'h00010, {34'd9, 17'd3, 17'd1});
        b_one(16'd5, 16'd5, 17'd14, {34'd16, 17'd4, 17'd1});

        for (int t = 0; t < 4; t++) begin
          load_vec(tbl[t]);
          a_run(-1, 1'b0, {tbl[t].mse, tbl[t].mx, tbl[t].cnt});
        end

        load_vec(tbl[2]);
        a_run(2, 1'b1, {tbl[2].mse, tbl[2].mx, tbl[2].cnt});

        for (int r = 0; r < 3; r++) begin
          for (int i = 0; i < 4; i++) begin
            w1[i] = 16'($urandom_range(0, 65535));
            w2[i] = 16'($urandom_range(0, 65535));
            if (i[0]) wa[i] = 17'($urandom_range(0, 131071));
            else wa[i] = 17'({1'b0, w1[i]} + {1'b0, w2[i]}) ^ 17'($urandom_range(0, 3));
          end
          a_run(-1, 1'b0, model());
        end

        // Abandon a window after two erroneous samples.
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_valid = 1'b1;
        a_in1 = 16'd0;
        a_in2 = 16'd0;
        a_approx = 17'd7;
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b0;
        rst_a = 1'b0;
        #1;
        check("midreset_results", {a_mse, a_max, a_cnt}, 68'd0);
        check("midreset_flags", {64'd0, a_done, a_ready, a_state}, 68'd0);
        #2;
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_idle", {64'd0, a_done, a_ready, a_state}, 68'd0);
        load_vec(tbl[0]);
        a_run(-1, 1'b0, 68'd0);
      end
    join

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_windows actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mse_error_accumulator.md
MSE_ERROR_ACCUMULATOR -- requirements
Module: mse_error_accumulator

Interface
REQ-001 Parameter LOG2N, default 4, meaning: log2 of samples per measurement window; legal range 0..16.
REQ-002 Parameter N derived: 2^LOG2N samples per window. SUM_W derived: 34+LOG2N bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; begins a new measurement window.
REQ-006 in_valid  input  1  sample present on IN1/IN2/APPROX.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 IN1  input  16  first operand given to the 16-bit approximate ripple adder under test.
REQ-009 IN2  input  16  second operand given to the same adder.
REQ-010 APPROX  input  17  that adder's Out for (IN1, IN2).
REQ-011 mse  output  34  sum of squared errors >> LOG2N, truncating.
REQ-012 max_abs_err  output  17  largest |error| in the window.
REQ-013 err_count  output  17  number of samples with nonzero error.
REQ-014 done  output  1  results valid; held until next start or reset.

Function
REQ-015 The states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-016 IDLE: in_ready=0. On start the block SHALL go to RUN, clear all accumulators and the sample counter, and drop done.
REQ-017 RUN: in_ready=1. A sample SHALL be accepted when in_valid && in_ready. After the N-th acceptance the block SHALL go to DRAIN and drop in_ready the next cycle.
REQ-018 DRAIN: in_ready=0. After the last accepted sample leaves the 2-stage pipeline, the block SHALL go to DONE, register the results and assert done.
REQ-019 DONE: in_ready=0 and outputs held stable. A start SHALL behave as in IDLE.
REQ-020 start SHALL be ignored in RUN and DRAIN.
REQ-021 Stage 1, the cycle after acceptance, SHALL register exact = IN1+IN2 (17-bit) and err = APPROX - exact as 18-bit two's complement.
REQ-022 Stage 2 SHALL compute |err| (17-bit) and err*err (34-bit unsigned), then:
- add err*err into a SUM_W-bit sum;
- update the running max with >= compare;
- increment err_count if err != 0.
REQ-023 Nothing SHALL wrap: |err| <= 2^17-1, its square fits in 34 bits, and N squares fit in SUM_W bits.
REQ-024 mse SHALL be sum[SUM_W-1:LOG2N].
REQ-025 done SHALL rise 3 cycles after the cycle the N-th sample is accepted.
REQ-026 in_valid gaps in RUN SHALL only stall the window; the pipeline SHALL advance only bubbles.
REQ-027 LOG2N=0: the window SHALL be one sample, and mse SHALL equal that sample's squared error.
REQ-028 Samples with in_valid=1 while in_ready=0 SHALL be neither counted nor accumulated.

Reset
REQ-029 While rst_n=0, independent of clk, the block SHALL be in IDLE with in_ready=0, done=0, mse=0, max_abs_err=0, err_count=0, and all accumulators, pipeline registers and the sample counter cleared.
REQ-030 A reset asserted in RUN or DRAIN SHALL abandon the partial window. After release the block SHALL wait in IDLE for start.
REQ-031 Reset deassertion SHALL alone never start a window.

Verification
REQ-032 Exact input, LOG2N=2: 4 samples with APPROX=IN1+IN2 (e.g. 0x1234+0x0F0F -> 0x02143) -> done after 3 cycles; mse=0, max_abs_err=0, err_count=0.
REQ-033 Constant error, LOG2N=2: 4 samples IN1=0x0010, IN2=0x0003, APPROX=0x00010 (err=-3) -> sum=36, mse=9, max_abs_err=3, err_count=4.
REQ-034 Mixed errors, LOG2N=2: errors +1, 0, -5, +2 -> sum=30, mse=7, max_abs_err=5, err_count=3.
REQ-035 Stall and ignore: in_valid low for 5 cycles mid-window, plus start pulsed in RUN -> same results as without the stall, and the window is not restarted.
REQ-036 Reset mid-window: rst_n low after 2 of 4 samples -> all outputs read 0 immediately. A new start plus 4 exact samples -> mse=0 and err_count=0, with no residue from the abandoned window.
REQ-037 Worst case, LOG2N=16: 65536 samples, APPROX=0, IN1=IN2=0xFFFF -> max_abs_err=0x1FFFE, mse=0x3FFF80004, no overflow.
